// File: rtl/gpio_access_master_if.sv
// Bundle of the signals between gpio_access_master, its command/response client and the GPIO responder.
// The master modport is the gpio_access_master view; the slave modport is the view of everything around it.
interface gpio_access_master_if #(
    parameter int PIN_AMOUNT           = 8,
    parameter int ADDR_INTERFACE_WIDTH = 64
);
    logic                            cmd_valid;
    logic                            cmd_ready;
    logic [2:0]                      cmd_op;
    logic [ADDR_INTERFACE_WIDTH-1:0] cmd_port;
    logic [PIN_AMOUNT-1:0]           cmd_data;
    logic [PIN_AMOUNT-1:0]           cmd_mask;

    logic                            rsp_valid;
    logic                            rsp_ready;
    logic [PIN_AMOUNT-1:0]           rsp_data;
    logic                            rsp_err;
    logic                            rsp_timeout;

    logic [ADDR_INTERFACE_WIDTH-1:0] raddr_PORT;
    logic [ADDR_INTERFACE_WIDTH-1:0] waddr_PORT;
    logic                            rd_req;
    logic                            wr_req;
    logic [PIN_AMOUNT-1:0]           wdata_PORT;
    logic [PIN_AMOUNT-1:0]           rdata_PORT;
    logic                            rd_available;
    logic                            wr_available;

    modport master (
        input  cmd_valid, cmd_op, cmd_port, cmd_data, cmd_mask, rsp_ready,
               rdata_PORT, rd_available, wr_available,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_timeout,
               raddr_PORT, waddr_PORT, rd_req, wr_req, wdata_PORT
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_port, cmd_data, cmd_mask, rsp_ready,
               rdata_PORT, rd_available, wr_available,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_timeout,
               raddr_PORT, waddr_PORT, rd_req, wr_req, wdata_PORT
    );
endinterface

// File: rtl/gpio_access_master.sv
// GPIO port access initiator: runs one read, write or read-modify-write per command and returns one response.
// Define GPIO_WAIT_OP_EN to enable the WAIT (poll until masked match) op; otherwise op 6 is rejected as reserved.
module gpio_access_master #(
    parameter int PORT_AMOUNT          = 2,
    parameter int PIN_AMOUNT           = 8,
    parameter int ADDR_INTERFACE_WIDTH = 64,
    parameter int WAIT_TIMEOUT         = 1024
) (
    input logic                clk,
    input logic                rst_n,
    gpio_access_master_if.master bus
);

    typedef enum logic [2:0] {
        OP_READ   = 3'd0,
        OP_WRITE  = 3'd1,
        OP_SET    = 3'd2,
        OP_CLEAR  = 3'd3,
        OP_TOGGLE = 3'd4,
        OP_MWRITE = 3'd5,
        OP_WAIT   = 3'd6,
        OP_RSVD   = 3'd7
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        RSP
`ifdef GPIO_WAIT_OP_EN
        , POLL
`endif
    } state_t;

    state_t                          state;
    op_t                             op_q;
    logic [ADDR_INTERFACE_WIDTH-1:0] addr_q;
    logic [PIN_AMOUNT-1:0]           data_q;
    logic [PIN_AMOUNT-1:0]           mask_q;
    logic [PIN_AMOUNT-1:0]           wdata_q;
    logic [PIN_AMOUNT-1:0]           rsp_data_q;
    logic                            rd_req_q;
    logic                            wr_req_q;
    logic                            rsp_valid_q;
    logic                            rsp_err_q;
    logic [PIN_AMOUNT-1:0]           rmw_value;

`ifdef GPIO_WAIT_OP_EN
    localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);
    logic [CNT_W-1:0] poll_cnt;
    logic             rsp_timeout_q;
    assign bus.rsp_timeout = rsp_timeout_q;
`else
    assign bus.rsp_timeout = 1'b0;
`endif

    // NOTE: reset is synchronous, so the registered strobes would still be high in the cycle rst_n
    // drops; gating them with rst_n keeps a write in flight from committing at the reset edge.
    assign bus.cmd_ready  = rst_n && (state == IDLE);
    assign bus.rd_req     = rst_n && rd_req_q;
    assign bus.wr_req     = rst_n && wr_req_q;
    assign bus.rsp_valid  = rst_n && rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.raddr_PORT = addr_q;
    assign bus.waddr_PORT = addr_q;
    assign bus.wdata_PORT = wdata_q;

    // Input-configured pins read back as pin levels and are written back as such on RMW.
    always_comb begin
        rmw_value = bus.rdata_PORT;
        case (op_q)
            OP_SET:    rmw_value = bus.rdata_PORT | data_q;
            OP_CLEAR:  rmw_value = bus.rdata_PORT & ~data_q;
            OP_TOGGLE: rmw_value = bus.rdata_PORT ^ data_q;
            OP_MWRITE: rmw_value = (bus.rdata_PORT & ~mask_q) | (data_q & mask_q);
            default:   rmw_value = bus.rdata_PORT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_q        <= OP_READ;
            addr_q      <= '0;
            data_q      <= '0;
            mask_q      <= '0;
            wdata_q     <= '0;
            rsp_data_q  <= '0;
            rd_req_q    <= 1'b0;
            wr_req_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
`ifdef GPIO_WAIT_OP_EN
            poll_cnt      <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.cmd_valid) begin
                    op_q   <= op_t'(bus.cmd_op);
                    addr_q <= bus.cmd_port;
                    data_q <= bus.cmd_data;
                    mask_q <= bus.cmd_mask;
`ifdef GPIO_WAIT_OP_EN
                    rsp_timeout_q <= 1'b0;
`endif
                    case (op_t'(bus.cmd_op))
                        OP_READ, OP_SET, OP_CLEAR, OP_TOGGLE, OP_MWRITE: begin
                            state    <= RD;
                            rd_req_q <= 1'b1;
                        end
                        OP_WRITE: begin
                            state    <= WR;
                            wr_req_q <= 1'b1;
                            wdata_q  <= bus.cmd_data;
                        end
`ifdef GPIO_WAIT_OP_EN
                        OP_WAIT: begin
                            state    <= POLL;
                            rd_req_q <= 1'b1;
                            poll_cnt <= CNT_W'(WAIT_TIMEOUT);
                        end
`endif
                        default: begin
                            state       <= RSP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= '0;
                        end
                    endcase
                end

                RD: begin
                    rd_req_q <= 1'b0;
                    if (!bus.rd_available || op_q == OP_READ) begin
                        state       <= RSP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= !bus.rd_available;
                        rsp_data_q  <= bus.rd_available ? bus.rdata_PORT : '0;
                    end else begin
                        state    <= WR;
                        wr_req_q <= 1'b1;
                        wdata_q  <= rmw_value;
                    end
                end

                WR: begin
                    wr_req_q    <= 1'b0;
                    state       <= RSP;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= !bus.wr_available;
                    rsp_data_q  <= wdata_q;
                end

                RSP: if (bus.rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    state       <= IDLE;
                end

`ifdef GPIO_WAIT_OP_EN
                POLL: begin
                    if (!bus.rd_available) begin
                        rd_req_q    <= 1'b0;
                        state       <= RSP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_data_q  <= '0;
                    end else if (((bus.rdata_PORT & mask_q) == (data_q & mask_q)) ||
                                 (poll_cnt <= CNT_W'(1))) begin
                        // Either a match, or this was the last allowed read.
                        rd_req_q      <= 1'b0;
                        state         <= RSP;
                        rsp_valid_q   <= 1'b1;
                        rsp_data_q    <= bus.rdata_PORT;
                        rsp_err_q     <= (bus.rdata_PORT & mask_q) != (data_q & mask_q);
                        rsp_timeout_q <= (bus.rdata_PORT & mask_q) != (data_q & mask_q);
                    end else begin
                        poll_cnt <= poll_cnt - CNT_W'(1);
                    end
                end
`endif

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_access_master.sv
// Randomized self-checking bench for gpio_access_master against a behavioural GPIO responder model.
// Exercises the WAIT op when GPIO_WAIT_OP_EN is defined, and checks it is rejected otherwise.
module tb_gpio_access_master;

    localparam int PORTS = 3;
    localparam int PINS  = 8;
    localparam int AW    = 64;
    localparam int WT    = 16;
`ifdef GPIO_WAIT_OP_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gpio_access_master_if #(.PIN_AMOUNT(PINS), .ADDR_INTERFACE_WIDTH(AW)) bus ();

    gpio_access_master #(
        .PORT_AMOUNT(PORTS), .PIN_AMOUNT(PINS),
        .ADDR_INTERFACE_WIDTH(AW), .WAIT_TIMEOUT(WT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    // Responder: per port an output register, a direction mask (1 = output) and pin levels.
    logic [7:0] out_reg [4] = '{default: '0};
    logic [7:0] exp_out [4] = '{default: '0};
    logic [7:0] dir     [4];
    logic [7:0] pins    [4];
    logic [1:0] ridx, widx;

    assign ridx = bus.raddr_PORT[1:0];
    assign widx = bus.waddr_PORT[1:0];
    assign bus.wr_available = bus.waddr_PORT < AW'(PORTS);

    always_comb begin
        bus.rd_available = 1'b0;
        bus.rdata_PORT   = '0;
        if (bus.raddr_PORT < AW'(PORTS)) begin
            bus.rd_available = 1'b1;
            bus.rdata_PORT   = (out_reg[ridx] & dir[ridx]) | (pins[ridx] & ~dir[ridx]);
        end
    end

    always @(posedge clk)
        if (bus.wr_req && bus.wr_available) out_reg[widx] <= bus.wdata_PORT;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       err;
        logic       tmo;
        int         lat;
        int         rds;
        int         wrs;
    } exp_t;

    function automatic logic [7:0] level(input int p, input logic [7:0] pin_v);
        return (exp_out[p] & dir[p]) | (pin_v & ~dir[p]);
    endfunction

    // Present a command at a negedge and return just after the accepting clock edge.
    task automatic issue(input int op, input logic [63:0] port, input logic [7:0] data,
                         input logic [7:0] mask);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'(op);
        bus.cmd_port  = port;
        bus.cmd_data  = data;
        bus.cmd_mask  = mask;
        while (!bus.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", 64'(n < 20), 64'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'($urandom);
        bus.cmd_port  = {$urandom, $urandom};
        bus.cmd_data  = 8'($urandom);
        bus.cmd_mask  = 8'($urandom);
    endtask

    // One full command: model expectation, bus observation, response and responder contents.
    task automatic run_cmd(input int op, input logic [63:0] port, input logic [7:0] data,
                           input logic [7:0] mask, input int hold, input int rise,
                           input logic [7:0] rise_bits);
        exp_t e;
        logic       avail;
        int         p, rds, wrs, first_wr, lat, bad, wbad;
        logic [7:0] old, nv, v, held_data;
        logic       held_err;

        avail = port < 64'(PORTS);
        p     = avail ? int'(port[1:0]) : 0;
        old   = level(p, pins[p]);
        e     = '{data: 8'h00, err: 1'b1, tmo: 1'b0, lat: 1, rds: 0, wrs: 0};

        if (op == 0) begin
            e.lat = 2; e.rds = 1;
            if (avail) begin e.data = old; e.err = 1'b0; end
        end else if (op == 1) begin
            e.lat = 2; e.wrs = 1; e.data = data; e.err = !avail;
            if (avail) exp_out[p] = data;
        end else if (op >= 2 && op <= 5) begin
            e.lat = 2; e.rds = 1;
            if (avail) begin
                for (int b = 0; b < 8; b++)
                    case (op)
                        2:       nv[b] = old[b] | data[b];
                        3:       nv[b] = data[b] ? 1'b0 : old[b];
                        4:       nv[b] = data[b] ? !old[b] : old[b];
                        default: nv[b] = mask[b] ? data[b] : old[b];
                    endcase
                e.lat = 3; e.wrs = 1; e.data = nv; e.err = 1'b0;
                exp_out[p] = nv;
            end
        end else if (op == 6 && WAIT_EN) begin
            e.lat = 2; e.rds = 1;
            if (avail) begin
                e.lat = WT + 1; e.rds = WT; e.tmo = 1'b1;
                for (int c = WT; c >= 1; c--) begin
                    v = (rise > 0 && c >= rise) ? level(p, pins[p] | rise_bits) : old;
                    if (c == WT) e.data = v;
                    if (((v ^ data) & mask) == 8'h00) begin
                        e.lat = c + 1; e.rds = c; e.data = v; e.err = 1'b0; e.tmo = 1'b0;
                    end
                end
            end
        end

        issue(op, port, data, mask);
        bus.rsp_ready = (hold == 0);
        rds = 0; wrs = 0; first_wr = 0; lat = 0; bad = 0; wbad = 0;
        for (int cyc = 1; cyc <= 40 && lat == 0; cyc++) begin
            if (cyc > 1) begin
                @(posedge clk);
                #1;
            end
            if (cyc == rise) pins[p] = pins[p] | rise_bits;
            @(negedge clk);
            if (bus.rd_req) begin
                rds++;
                if (bus.raddr_PORT !== port) bad++;
            end
            if (bus.wr_req) begin
                wrs++;
                if (first_wr == 0) first_wr = cyc;
                if (bus.waddr_PORT !== port || bus.wdata_PORT !== e.data) wbad++;
            end
            if (bus.cmd_ready) bad++;
            if (bus.rsp_valid) lat = cyc;
        end

        check($sformatf("op%0d_latency", op), 64'(lat), 64'(e.lat));
        check($sformatf("op%0d_rsp_data", op), 64'(bus.rsp_data), 64'(e.data));
        check($sformatf("op%0d_rsp_err", op), 64'(bus.rsp_err), 64'(e.err));
        check($sformatf("op%0d_rsp_timeout", op), 64'(bus.rsp_timeout), 64'(e.tmo));
        check($sformatf("op%0d_rd_cycles", op), 64'(rds), 64'(e.rds));
        check($sformatf("op%0d_wr_cycles", op), 64'(wrs), 64'(e.wrs));
        check($sformatf("op%0d_addr_ready", op), 64'(bad), 64'd0);
        if (e.wrs > 0) check($sformatf("op%0d_wr_bus", op), 64'(wbad), 64'd0);
        if (e.wrs > 0 && e.rds > 0) check("rmw_rd_then_wr", 64'(first_wr), 64'd2);

        held_data = bus.rsp_data;
        held_err  = bus.rsp_err;
        if (hold > 0) begin
            bad = 0;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (!bus.rsp_valid || bus.cmd_ready || bus.rsp_data !== held_data ||
                    bus.rsp_err !== held_err) bad++;
            end
            check("backpressure_stable", 64'(bad), 64'd0);
            bus.rsp_ready = 1'b1;
        end
        @(negedge clk);
        check("ready_after_rsp", 64'({bus.cmd_ready, bus.rsp_valid}), 64'b10);
        if (avail) check($sformatf("port%0d_value", p), 64'(out_reg[p]), 64'(exp_out[p]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] rport;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_port  = '0;
        bus.cmd_data  = '0;
        bus.cmd_mask  = '0;
        bus.rsp_ready = 1'b1;
        dir  = '{8'h00, 8'hFF, 8'($urandom), 8'hFF};
        pins = '{8'hA5, 8'h00, 8'($urandom), 8'h00};

        repeat (3) @(negedge clk);
        check("reset_outputs", 64'(|{bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err,
              bus.rsp_timeout, bus.raddr_PORT, bus.waddr_PORT, bus.rd_req, bus.wr_req,
              bus.wdata_PORT}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(bus.cmd_ready), 64'd1);

        run_cmd(0, 64'd0, 8'h00, 8'h00, 0, 0, 8'h00);   // READ input pins 0xA5
        check("read_port0_const", 64'(bus.rsp_data), 64'hA5);
        run_cmd(1, 64'd1, 8'h3C, 8'h00, 0, 0, 8'h00);   // WRITE 0x3C
        run_cmd(0, 64'd1, 8'h00, 8'h00, 0, 0, 8'h00);   // read back
        check("readback_const", 64'(bus.rsp_data), 64'h3C);
        run_cmd(2, 64'd1, 8'h81, 8'h00, 0, 0, 8'h00);   // SET    -> 0xBD
        run_cmd(3, 64'd1, 8'h0C, 8'h00, 0, 0, 8'h00);   // CLEAR  -> 0xB1
        run_cmd(4, 64'd1, 8'hFF, 8'h00, 0, 0, 8'h00);   // TOGGLE -> 0x4E
        run_cmd(5, 64'd1, 8'hF0, 8'h3C, 0, 0, 8'h00);   // MWRITE -> 0x72
        check("rmw_chain_const", 64'(out_reg[1]), 64'h72);

        run_cmd(2, 64'd3, 8'h01, 8'h00, 0, 0, 8'h00);   // unavailable port
        run_cmd(7, 64'd1, 8'h55, 8'hFF, 0, 0, 8'h00);   // reserved op
        run_cmd(0, 64'd0, 8'h00, 8'h00, 5, 0, 8'h00);   // backpressure 5 cycles

        // Reset while the write strobe is up: no commit, everything cleared.
        issue(1, 64'd1, 8'h55, 8'h00);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_in_wr_strobes", 64'({bus.wr_req, bus.rd_req, bus.cmd_ready, bus.rsp_valid}),
              64'd0);
        @(posedge clk);
        #1;
        check("rst_in_wr_port_kept", 64'(out_reg[1]), 64'(exp_out[1]));
        @(negedge clk);
        check("rst_in_wr_outputs", 64'(|{bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err,
              bus.rsp_timeout, bus.raddr_PORT, bus.waddr_PORT, bus.rd_req, bus.wr_req,
              bus.wdata_PORT}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        pins[0] = 8'hA4;
        run_cmd(6, 64'd0, 8'h01, 8'h01, 0, 10, 8'h01);  // pin 0 rises in poll cycle 10
        pins[0] = 8'hA4;
        run_cmd(6, 64'd0, 8'h01, 8'h01, 0, 0, 8'h00);   // never matches
        if (WAIT_EN) check("wait_timeout_flag", 64'(bus.rsp_timeout), 64'd1);
        pins[0] = 8'hA5;

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 4))
                0, 1, 2: rport = 64'($urandom_range(0, 2));
                3:       rport = 64'd3;
                default: rport = {32'hFFFF_0000, $urandom};
            endcase
            if ($urandom_range(0, 3) == 0) pins[$urandom_range(0, 2)] = 8'($urandom);
            run_cmd(int'($urandom_range(0, 7)), rport, 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, 2)), 0, 8'h00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_access_master.md
Name: gpio_access_master

Overview:
- Initiator for the GPIO port register interface. Drives rd_req/wr_req, raddr_PORT/waddr_PORT and wdata_PORT toward the GPIO responder.
- Accepts single commands from the load-store unit over a valid/ready handshake. Each command is a plain read, a plain write, or a read-modify-write: set, clear, toggle or masked write.
- Returns one response per command carrying result data and an error flag.
- Sits between the core's memory-mapped I/O path and the GPIO responder.

Parameters:
- PORT_AMOUNT, 2, number of GPIO ports addressable at the responder.
- PIN_AMOUNT, 8, pins per port; width of all data and mask paths.
- ADDR_INTERFACE_WIDTH, 64, width of cmd_port, raddr_PORT and waddr_PORT.
- WAIT_TIMEOUT, 1024, maximum poll reads for the WAIT op (only used with GPIO_WAIT_OP_EN).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  master can accept a command
- cmd_op  in  3  0 READ, 1 WRITE, 2 SET, 3 CLEAR, 4 TOGGLE, 5 MWRITE, 6 WAIT, 7 reserved
- cmd_port  in  ADDR_INTERFACE_WIDTH  target port index
- cmd_data  in  PIN_AMOUNT  operand
- cmd_mask  in  PIN_AMOUNT  bit mask for MWRITE/WAIT
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_data  out  PIN_AMOUNT  read value, or value written
- rsp_err  out  1  port unavailable or illegal op
- rsp_timeout  out  1  WAIT expired
- raddr_PORT  out  ADDR_INTERFACE_WIDTH  read port address
- waddr_PORT  out  ADDR_INTERFACE_WIDTH  write port address
- rd_req  out  1  read strobe
- wr_req  out  1  write strobe
- wdata_PORT  out  PIN_AMOUNT  write data
- rdata_PORT  in  PIN_AMOUNT  read data (combinational from raddr_PORT)
- rd_available  in  1  read port valid
- wr_available  in  1  write port valid

Behaviour:
- Reset: all outputs 0 and state IDLE; any pending response is discarded. Reset has priority over every other event, including a strobe in flight; rd_req/wr_req are 0 in the reset cycle.
- Responder timing: read data and rd_available are combinational in the same cycle as raddr_PORT; a write commits at the clk edge that ends a cycle with wr_req=1 and wr_available=1.
- FSM states: IDLE, RD, WR, RSP (plus POLL with the optional feature).
- IDLE:
  - cmd_ready=1 only in IDLE. On cmd_valid&cmd_ready, latch op, port, data and mask.
  - Both address outputs take the latched port; they hold their last value while idle.
  - Next state: READ/SET/CLEAR/TOGGLE/MWRITE -> RD; WRITE -> WR; reserved op -> RSP with rsp_err=1, rsp_data=0 and no bus strobe.
- RD (1 cycle): rd_req=1.
  - rd_available=0 -> RSP with err=1, data=0; no write is issued.
  - READ -> RSP with data=rdata_PORT.
  - RMW ops -> compute new = SET old|data, CLEAR old&~data, TOGGLE old^data, MWRITE (old&~mask)|(data&mask); old = rdata_PORT; then -> WR.
  - Input-configured pins return pin levels, and RMW writes those levels back into the output register. This is intended.
- WR (1 cycle): wr_req=1 and wdata_PORT = latched data (WRITE) or new value (RMW).
  - wr_available=0 -> err=1.
  - rsp_data = value driven on wdata_PORT. Then -> RSP.
- RSP: rsp_valid=1. rsp_data, rsp_err and rsp_timeout are held stable until rsp_ready=1, then -> IDLE.
  - rsp_valid and cmd_ready are never high together. rd_req/wr_req are 0 outside RD/WR/POLL.
- Latency from accept edge to rsp_valid: READ/WRITE 2 cycles, RMW 3 cycles, reserved op 1 cycle.
- Throughput: one command every latency+1 cycles when rsp_ready is held high.

Optional Feature:
- Macro GPIO_WAIT_OP_EN.
- Defined:
  - Op 6 (WAIT) is accepted and goes to POLL. POLL asserts rd_req every cycle with a down-counter loaded to WAIT_TIMEOUT on accept.
  - Match when (rdata_PORT&mask)==(data&mask) -> RSP with data=rdata_PORT.
  - rd_available=0 -> RSP with err=1.
  - After WAIT_TIMEOUT reads without a match -> RSP with err=1, rsp_timeout=1, data = last read.
- Undefined: op 6 is handled as reserved (err=1, no bus access). rsp_timeout is tied 0 and the counter is not instantiated.

Test Plan:
- Reset, READ port 0 with pins 0xA5 input-configured -> one rd_req cycle at raddr=0; rsp_valid 2 cycles after accept, rsp_data=0xA5, rsp_err=0.
- WRITE port 1 0x3C -> single wr_req cycle, waddr=1, wdata=0x3C; responder reads back 0x3C; rsp_data=0x3C.
- RMW chain on port 1 (all pins output, starting 0x3C):
  - SET 0x81 -> 0xBD.
  - CLEAR 0x0C -> 0xB1.
  - TOGGLE 0xFF -> 0x4E.
  - MWRITE data 0xF0, mask 0x3C -> 0x72.
  - Each shows rd then wr on consecutive cycles.
- Responder with PORT_AMOUNT=3, SET to port 3 -> rd_available=0, rsp_err=1, rsp_data=0, no wr_req; op 7 -> rsp_err=1 after 1 cycle with no strobes.
- Backpressure and reset:
  - Hold rsp_ready=0 for 5 cycles -> rsp_valid/data stable, cmd_ready=0.
  - Assert rst_n=0 during WR -> wr_req=0 that cycle, port value unchanged, all outputs 0.
- GPIO_WAIT_OP_EN, WAIT mask 0x01 data 0x01:
  - Pin 0 rises after 10 cycles -> rsp_data bit0=1, timeout=0.
  - With WAIT_TIMEOUT=16 and pin never rising -> exactly 16 rd_req cycles, rsp_err=1, rsp_timeout=1.
